// File: rtl/pila_param_pkg.sv
// Shared stack constants and the {push,pop} operation encoding used by the
// CPU control unit and the return-address stack.
package pila_param_pkg;

  localparam int unsigned PILA_WIDTH = 10;
  localparam int unsigned PILA_DEPTH = 16;

  // Encoding is {push, pop}.
  typedef enum logic [1:0] {
    OpNop  = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpRepl = 2'b11
  } pila_op_e;

endpackage

// File: rtl/pila_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, two combinational
// read ports (top of stack and debug). Storage has no reset; the caller masks
// every read by occupancy, so stale contents never leak out.
module pila_mem
  import pila_param_pkg::*;
#(
  parameter int unsigned WIDTH = PILA_WIDTH,
  parameter int unsigned DEPTH = PILA_DEPTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_top,
  input  logic [AW-1:0]    i_raddr_dbg,
  output logic [WIDTH-1:0] o_rdata_top,
  output logic [WIDTH-1:0] o_rdata_dbg
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Single write port; the controller only ever presents in-range addresses.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous reads for the PC mux and the debug port.
  always_comb begin
    o_rdata_top = r_mem[i_raddr_top];
    o_rdata_dbg = r_mem[i_raddr_dbg];
  end

endmodule

// File: rtl/pila_param.sv
// Parametrised LIFO return-address stack. Holds the occupancy counter and the
// sticky error flags; storage lives in pila_mem. Priority: reset > flush >
// push/pop. Simultaneous push+pop replaces the top entry.
module pila_param
  import pila_param_pkg::*;
#(
  parameter int unsigned WIDTH = PILA_WIDTH,
  parameter int unsigned DEPTH = PILA_DEPTH,
  parameter int unsigned PTRW  = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic             i_clr_err,
  input  logic [WIDTH-1:0] i_din,
  input  logic [PTRW-1:0]  i_dbg_idx,
  output logic [WIDTH-1:0] o_dout,
  output logic [WIDTH-1:0] o_dbg_dout,
  output logic [PTRW-1:0]  o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTRW-1:0]  r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic [PTRW-1:0]  w_count_d;
  logic             w_overflow_d;
  logic             w_underflow_d;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_top_addr;
  logic [AW-1:0]    w_dbg_addr;
  logic [WIDTH-1:0] w_rdata_top;
  logic [WIDTH-1:0] w_rdata_dbg;
  logic             w_empty;
  logic             w_full;
  logic             w_dbg_valid;
  pila_op_e         w_op;

  assign w_op    = pila_op_e'({i_push, i_pop});
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == PTRW'(DEPTH));

  // Next occupancy, write request and sticky flags; a set in the same cycle
  // as clr_err wins over the clear.
  always_comb begin
    w_count_d     = r_count;
    w_we          = 1'b0;
    w_waddr       = AW'(r_count);
    w_overflow_d  = r_overflow  & ~i_clr_err;
    w_underflow_d = r_underflow & ~i_clr_err;
    if (i_flush) begin
      w_count_d = '0;
    end else begin
      unique case (w_op)
        OpPush: begin
          if (w_full) begin
            w_overflow_d = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_count_d = r_count + PTRW'(1);
          end
        end
        OpPop: begin
          if (w_empty) begin
            w_underflow_d = 1'b1;
          end else begin
            w_count_d = r_count - PTRW'(1);
          end
        end
        OpRepl: begin
          // On an empty stack this degenerates to a plain push into slot 0.
          w_we = 1'b1;
          if (w_empty) begin
            w_count_d = PTRW'(1);
          end else begin
            w_waddr = AW'(r_count - PTRW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // Synchronous reset clears occupancy and flags; storage is left alone.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
    end
  end

  // Read addresses: top is count-1, debug index counts down from the top.
  always_comb begin
    w_top_addr  = AW'(r_count - PTRW'(1));
    w_dbg_addr  = AW'(r_count - PTRW'(1) - i_dbg_idx);
    w_dbg_valid = (i_dbg_idx < r_count);
  end

  pila_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk       (i_clk),
    .i_we        (w_we & ~i_reset),
    .i_waddr     (w_waddr),
    .i_wdata     (i_din),
    .i_raddr_top (w_top_addr),
    .i_raddr_dbg (w_dbg_addr),
    .o_rdata_top (w_rdata_top),
    .o_rdata_dbg (w_rdata_dbg)
  );

  // Outputs are masked by occupancy so unwritten or popped slots read as 0.
  always_comb begin
    o_dout      = w_empty ? '0 : w_rdata_top;
    o_dbg_dout  = w_dbg_valid ? w_rdata_dbg : '0;
    o_count     = r_count;
    o_empty     = w_empty;
    o_full      = w_full;
    o_overflow  = r_overflow;
    o_underflow = r_underflow;
  end

endmodule

// File: tb/tb_pila_param.sv
// Directed bench for pila_param at WIDTH=10, DEPTH=16.
module tb_pila_param;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTRW  = 5;

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] din;
  logic [PTRW-1:0]  dbg_idx;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dbg_dout;
  logic [PTRW-1:0]  count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int n_vec;
  int n_err;

  pila_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_push      (push),
    .i_pop       (pop),
    .i_flush     (flush),
    .i_clr_err   (clr_err),
    .i_din       (din),
    .i_dbg_idx   (dbg_idx),
    .o_dout      (dout),
    .o_dbg_dout  (dbg_dout),
    .o_count     (count),
    .o_empty     (empty),
    .o_full      (full),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of controls, then return to idle and sample 1 ns later.
  task automatic cyc(input logic pu, input logic po, input logic fl, input logic ce,
                     input logic [WIDTH-1:0] d);
    push = pu; pop = po; flush = fl; clr_err = ce; din = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; din = '0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    din = '0; dbg_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    check("rst_dbg", 32'(dbg_dout), 0);

    // Three pushes, debug reads, three pops.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h001);
    check("push1_dout", 32'(dout), 32'h001);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h002);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h003);
    check("push3_count", 32'(count), 3);
    check("push3_dout", 32'(dout), 32'h003);
    dbg_idx = 5'd2; #1;
    check("dbg2", 32'(dbg_dout), 32'h001);
    dbg_idx = 5'd1; #1;
    check("dbg1", 32'(dbg_dout), 32'h002);
    dbg_idx = 5'd3; #1;
    check("dbg3_oob", 32'(dbg_dout), 0);
    dbg_idx = 5'd0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("pop1_dout", 32'(dout), 32'h002);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("pop2_dout", 32'(dout), 32'h001);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("pop3_dout", 32'(dout), 0);
    check("pop3_empty", 32'(empty), 1);
    check("pop3_unf", 32'(underflow), 0);

    // Fill to DEPTH with 0x011..0x020, then overflow.
    for (int k = 1; k <= 16; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'(32'h10 + k));
    check("fill_count", 32'(count), 16);
    check("fill_full", 32'(full), 1);
    check("fill_dout", 32'(dout), 32'h020);
    check("fill_ovf", 32'(overflow), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF);
    check("ovf_count", 32'(count), 16);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_dout", 32'(dout), 32'h020);
    dbg_idx = 5'd15; #1;
    check("ovf_dbg15", 32'(dbg_dout), 32'h011);
    dbg_idx = 5'd0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'h155);
    check("repl_full_dout", 32'(dout), 32'h155);
    check("repl_full_count", 32'(count), 16);
    check("repl_full_ovf", 32'(overflow), 1);
    dbg_idx = 5'd1; #1;
    check("repl_full_dbg1", 32'(dbg_dout), 32'h01F);
    dbg_idx = 5'd0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("clr_ovf", 32'(overflow), 0);

    // Flush, then underflow behaviour.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("flush_count", 32'(count), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("unf_flag", 32'(underflow), 1);
    check("unf_count", 32'(count), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    check("unf_set_wins", 32'(underflow), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("unf_clr", 32'(underflow), 0);

    // Push+pop on empty acts as push.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'h0AA);
    check("repl_empty_count", 32'(count), 1);
    check("repl_empty_dout", 32'(dout), 32'h0AA);
    check("repl_empty_unf", 32'(underflow), 0);

    // Flush wins over push; sticky flags survive a flush.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'(32'h40 + k));
    check("five_count", 32'(count), 5);
    check("five_dout", 32'(dout), 32'h044);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'h077);
    check("flushpush_count", 32'(count), 0);
    check("flushpush_unf", 32'(underflow), 1);
    check("flushpush_dout", 32'(dout), 0);

    // Mid-stream reset with push held high.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h101);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h102);
    check("pre_rst_count", 32'(count), 2);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h103);
    check("midrst_count", 32'(count), 0);
    check("midrst_unf", 32'(underflow), 0);
    check("midrst_dout", 32'(dout), 0);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h2B4);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_dout", 32'(dout), 32'h2B4);
    dbg_idx = 5'd1; #1;
    check("post_rst_dbg_stale", 32'(dbg_dout), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
